memb_loader: RTL and testbench

MEMB_LOADER -- requirements
Module: memb_loader

---
 rtl/memb_loader_pkg.sv | 18 +
 rtl/memb_loader_if.sv | 16 +
 rtl/memb_loader.sv | 102 ++++++++++
 tb/tb_memb_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/memb_loader_pkg.sv
// Shared types and defaults for the systolic B-operand loader.
package memb_loader_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } memb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memb_loader_if.sv
// Upstream row handshake: valid/ready with one packed row of DIM elements.
interface memb_loader_if
  import memb_loader_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DIM*BITS_AB-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/memb_loader.sv
// Loads one DIM x DIM tile row-by-row into the B buffer, then shifts
// DRAIN_CYCLES zero rows through it and pulses done.
module memb_loader
  import memb_loader_pkg::*;
#(
  parameter int BITS_AB      = BITS_AB_DEF,
  parameter int DIM          = DIM_DEF,
  parameter int DRAIN_CYCLES = 2*DIM-1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  memb_loader_if.slave              up,
  output logic signed [BITS_AB-1:0] Bout [DIM],
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_MAX = max_int(DIM, DRAIN_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  memb_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic xfer, load_row, load_zero, en_nx;
  logic signed [BITS_AB-1:0] row [DIM];

  for (genvar i = 0; i < DIM; i++) begin : g_unpack
    assign row[i] = up.in_data[i*BITS_AB +: BITS_AB];
  end

  assign up.in_ready = (state == FILL);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign xfer        = up.in_valid && up.in_ready;

  // DRAIN spans DRAIN_CYCLES+1 cycles: its first cycle still shows the last
  // registered row, so the count runs to DRAIN_CYCLES before leaving.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    en_nx     = 1'b0;
    load_row  = 1'b0;
    load_zero = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = FILL;
          cnt_nx   = '0;
        end
      end
      FILL: begin
        if (xfer) begin
          load_row = 1'b1;
          en_nx    = 1'b1;
          if (cnt == CW'(DIM - 1)) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES)) begin
          state_nx = FIN;
          cnt_nx   = '0;
        end else begin
          load_zero = 1'b1;
          en_nx     = 1'b1;
          cnt_nx    = cnt + CW'(1);
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en   <= 1'b0;
      Bout <= '{default: '0};
    end else begin
      en <= en_nx;
      if (load_row)
        Bout <= row;
      else if (load_zero)
        Bout <= '{default: '0};
    end
  end

endmodule

// File: tb/tb_memb_loader.sv
// Directed checks of memb_loader: tile load, gaps, sign, ignored start, resets.
module tb_memb_loader;

  localparam int B = 8;
  localparam int D = 8;
  localparam int NDRAIN = 2*D - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic signed [B-1:0] bout [D];
  logic en, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  memb_loader_if #(.BITS_AB(B), .DIM(D)) bus ();

  memb_loader #(.BITS_AB(B), .DIM(D), .DRAIN_CYCLES(NDRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .up    (bus),
    .Bout  (bout),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // variant 0: r*8+i; variant 1: element 0 = -128, element 7 = +127, rest r*8+i
  function automatic int exp_elem(input int v, input int r, input int i);
    if (v == 1 && i == 0) return -128;
    if (v == 1 && i == D-1) return 127;
    return r*D + i;
  endfunction

  function automatic logic [D*B-1:0] pack_row(input int v, input int r);
    logic [D*B-1:0] p;
    p = '0;
    for (int i = 0; i < D; i++) p[i*B +: B] = 8'(exp_elem(v, r, i));
    return p;
  endfunction

  task automatic chk_row(input string tag, input int v, input int r);
    for (int i = 0; i < D; i++)
      chk($sformatf("%s_r%0d_e%0d", tag, r, i), bout[i], exp_elem(v, r, i));
  endtask

  function automatic int nonzero_cnt();
    int n;
    n = 0;
    for (int i = 0; i < D; i++) if (bout[i] != 0) n++;
    return n;
  endfunction

  task automatic run_tile(input int v, input logic [7:0] gaps, input bit poke, input int rst_at);
    int seen_en, seen_done;
    bus.in_valid = 1'b1;
    bus.in_data  = pack_row(v, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("fill_busy", busy, 1);
    chk("fill_rdy", bus.in_ready, 1);
    for (int r = 0; r < D; r++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pack_row(v, r);
      if (poke && r == 3) start = 1'b1;
      tick;
      start = 1'b0;
      chk($sformatf("row_en_r%0d", r), en, 1);
      chk_row("row", v, r);
      if (gaps[r] && r < D-1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        tick;
        chk($sformatf("gap_en_r%0d", r), en, 0);
        chk_row("gap_hold", v, r);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("drain_rdy", bus.in_ready, 0);
    for (int d = 0; d < NDRAIN; d++) begin
      if (d == rst_at) begin
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_en", en, 0);
        chk("rst_bout", nonzero_cnt(), 0);
        chk("rst_rdy", bus.in_ready, 0);
        seen_en = 0;
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
          tick;
          if (en) seen_en++;
          if (done) seen_done++;
        end
        chk("rst_no_en", seen_en, 0);
        chk("rst_no_done", seen_done, 0);
        return;
      end
      tick;
      chk($sformatf("drain_en_%0d", d), en, 1);
      chk($sformatf("drain_zero_%0d", d), nonzero_cnt(), 0);
    end
    tick;
    chk("fin_done", done, 1);
    chk("fin_en", en, 0);
    chk("fin_busy", busy, 1);
    if (poke) start = 1'b1;
    tick;
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_en", en, 0);
    tick;
    chk("idle_stay", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick;
    tick;
    chk("reset_busy", busy, 0);
    chk("reset_en", en, 0);
    chk("reset_done", done, 0);
    chk("reset_rdy", bus.in_ready, 0);
    chk("reset_bout", nonzero_cnt(), 0);
    rst_n = 1'b1;
    tick;

    run_tile(0, 8'h00, 1'b0, -1);
    run_tile(0, 8'h55, 1'b0, -1);
    run_tile(1, 8'h00, 1'b0, -1);
    run_tile(0, 8'h00, 1'b1, -1);

    bus.in_valid = 1'b1;
    bus.in_data  = pack_row(0, 0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("idle_rdy_%0d", k), bus.in_ready, 0);
      chk($sformatf("idle_noen_%0d", k), en, 0);
    end
    run_tile(0, 8'h00, 1'b0, -1);

    run_tile(0, 8'h00, 1'b0, 5);

    bus.in_valid = 1'b1;
    bus.in_data  = pack_row(0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus.in_data = pack_row(0, r);
      tick;
    end
    chk("midfill_bout_pre", bout[0], 16);
    bus.in_data = pack_row(0, 3);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("midfill_busy", busy, 0);
    chk("midfill_en", en, 0);
    chk("midfill_bout", nonzero_cnt(), 0);
    chk("midfill_rdy", bus.in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("midfill_quiet_%0d", k), en | done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
